// File: rtl/irq_sched.sv
// Fixed-priority interrupt scheduler: NMI > irq line 13 .. line 0 (watchdog ORed onto WDT_VEC).
// Optional macro IRQ_NMI_SYNC_EN: treat nmi_evt as asynchronous (2-flop sync + rising-edge detect).
module irq_sched #(
    parameter int WDT_VEC = 10,
    parameter int HOLDOFF = 1
) (
    input  logic        mclk,
    input  logic        puc,
    input  logic [13:0] irq_in,
    input  logic        wdt_irq,
    input  logic        nmi_evt,
    input  logic        gie,
    input  logic        inst_bnd,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [3:0]  irq_num,
    output logic [13:0] irq_acc,
    output logic        nmi_acc
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

    state_t      state, state_nxt;
    logic [1:0]  hold_cnt, hold_cnt_nxt;
    logic        req_nxt;
    logic [3:0]  num_nxt;
    logic [13:0] acc_nxt;
    logic        nmi_acc_nxt;
    logic        nmi_pend, nmi_set, nmi_clr;
    logic [13:0] wdt_line, eff;
    logic        win_vld, locked_live;
    logic [3:0]  win_num;

`ifdef IRQ_NMI_SYNC_EN
    logic nmi_s1, nmi_s2, nmi_s3;

    always_ff @(posedge mclk or posedge puc) begin
        if (puc) begin
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            nmi_s3 <= 1'b0;
        end else begin
            nmi_s1 <= nmi_evt;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
        end
    end

    assign nmi_set = nmi_s2 & ~nmi_s3;
`else
    assign nmi_set = nmi_evt;
`endif

    // A new event in the same cycle as the acknowledge is a fresh NMI, so set wins.
    always_ff @(posedge mclk or posedge puc) begin
        if (puc)
            nmi_pend <= 1'b0;
        else if (nmi_set)
            nmi_pend <= 1'b1;
        else if (nmi_clr)
            nmi_pend <= 1'b0;
    end

    always_comb begin
        wdt_line          = '0;
        wdt_line[WDT_VEC] = wdt_irq;
        eff               = (irq_in | wdt_line) & {14{gie}};
    end

    always_comb begin
        win_vld = nmi_pend | (|eff);
        win_num = '0;
        for (int i = 0; i < 14; i++) begin
            if (eff[i])
                win_num = 4'(i);
        end
        if (nmi_pend)
            win_num = 4'd14;
    end

    assign locked_live = (irq_num == 4'd14) || eff[irq_num];

    always_ff @(posedge mclk or posedge puc) begin
        if (puc) begin
            state    <= IDLE;
            hold_cnt <= '0;
            irq_req  <= 1'b0;
            irq_num  <= '0;
            irq_acc  <= '0;
            nmi_acc  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            irq_req  <= req_nxt;
            irq_num  <= num_nxt;
            irq_acc  <= acc_nxt;
            nmi_acc  <= nmi_acc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        req_nxt      = irq_req;
        num_nxt      = irq_num;
        acc_nxt      = '0;
        nmi_acc_nxt  = 1'b0;
        nmi_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld && inst_bnd) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    num_nxt   = win_num;
                end
            end
            REQ: begin
                // irq_ack takes precedence over a same-cycle drop of the locked line.
                if (irq_ack) begin
                    state_nxt = ACK;
                    req_nxt   = 1'b0;
                    if (irq_num == 4'd14) begin
                        nmi_acc_nxt = 1'b1;
                        nmi_clr     = 1'b1;
                    end else begin
                        acc_nxt = 14'd1 << irq_num;
                    end
                end else if (!locked_live) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            ACK: begin
                state_nxt    = HOLD;
                hold_cnt_nxt = 2'(HOLDOFF - 1);
            end
            HOLD: begin
                if (hold_cnt == 2'd0)
                    state_nxt = IDLE;
                else
                    hold_cnt_nxt = hold_cnt - 2'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched: directed scenarios plus randomized transactions vs a priority model.
module tb_irq_sched;

    localparam int WDT_VEC = 10;
    localparam int HOLDOFF = 1;
`ifdef IRQ_NMI_SYNC_EN
    localparam int NMI_LAT = 4;
`else
    localparam int NMI_LAT = 2;
`endif

    logic        mclk = 1'b0;
    logic        puc;
    logic [13:0] irq_in;
    logic        wdt_irq, nmi_evt, gie, inst_bnd, irq_ack;
    logic        irq_req;
    logic [3:0]  irq_num;
    logic [13:0] irq_acc;
    logic        nmi_acc;

    int tests = 0;
    int fails = 0;

    irq_sched #(.WDT_VEC(WDT_VEC), .HOLDOFF(HOLDOFF)) dut (
        .mclk(mclk), .puc(puc), .irq_in(irq_in), .wdt_irq(wdt_irq), .nmi_evt(nmi_evt),
        .gie(gie), .inst_bnd(inst_bnd), .irq_ack(irq_ack), .irq_req(irq_req),
        .irq_num(irq_num), .irq_acc(irq_acc), .nmi_acc(nmi_acc)
    );

    always #5 mclk = ~mclk;

    task automatic step;
        @(negedge mclk);
    endtask

    task automatic clear_inputs;
        irq_in = '0; wdt_irq = 0; nmi_evt = 0; gie = 0; inst_bnd = 0; irq_ack = 0;
    endtask

    task automatic do_reset;
        puc = 1; clear_inputs();
        step(); step();
        puc = 0;
    endtask

    // Highest-priority pending source from the arbitration rules, scanned top-down.
    task automatic model_winner(input logic nmi, input logic [13:0] lines, input logic wdt,
                                input logic ge, output logic [3:0] num, output logic any);
        logic [13:0] v;
        v   = ge ? (lines | (14'd1 << WDT_VEC) & {14{wdt}}) : 14'd0;
        any = 0; num = 0;
        if (nmi) begin any = 1; num = 14; end
        else begin
            for (int b = 13; b >= 0; b--) begin
                if (!any && v[b]) begin any = 1; num = 4'(b); end
            end
        end
    endtask

    task automatic test_reset;
        puc = 1; irq_in = 14'h3FFF; wdt_irq = 1; nmi_evt = 1; gie = 1; inst_bnd = 1; irq_ack = 1;
        step(); step(); step();
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b want 0", irq_req); end
        tests++; if (irq_acc !== 14'h0) begin fails++; $display("FAIL reset_acc: got %h want 0000", irq_acc); end
        tests++; if (nmi_acc !== 1'b0) begin fails++; $display("FAIL reset_nmi_acc: got %0b want 0", nmi_acc); end
        tests++; if (irq_num !== 4'd0) begin fails++; $display("FAIL reset_num: got %0d want 0", irq_num); end
        irq_in = 14'h0008; wdt_irq = 0; nmi_evt = 0; irq_ack = 0; gie = 1; inst_bnd = 1;
        puc = 0;
        step();
        tests++; if (irq_req !== 1'b1 || irq_num !== 4'd3) begin fails++;
            $display("FAIL reset_release: got req=%0b num=%0d want req=1 num=3", irq_req, irq_num); end
    endtask

    task automatic test_priority_lock;
        do_reset();
        irq_in = 14'h0009; gie = 1; inst_bnd = 1;
        step();
        tests++; if (irq_req !== 1'b1 || irq_num !== 4'd3) begin fails++;
            $display("FAIL prio_first: got req=%0b num=%0d want req=1 num=3", irq_req, irq_num); end
        irq_in[12] = 1;
        step(); step();
        tests++; if (irq_req !== 1'b1 || irq_num !== 4'd3) begin fails++;
            $display("FAIL prio_lock: got req=%0b num=%0d want req=1 num=3", irq_req, irq_num); end
        irq_ack = 1; step(); irq_ack = 0;
        tests++; if (irq_acc !== 14'h0008 || irq_req !== 1'b0) begin fails++;
            $display("FAIL prio_ack: got acc=%h req=%0b want acc=0008 req=0", irq_acc, irq_req); end
        step();
        tests++; if (irq_acc !== 14'h0000) begin fails++; $display("FAIL prio_ack_width: got acc=%h want 0000", irq_acc); end
        step();
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL prio_holdoff: got req=%0b want 0", irq_req); end
        step();
        tests++; if (irq_req !== 1'b1 || irq_num !== 4'd12) begin fails++;
            $display("FAIL prio_rearb: got req=%0b num=%0d want req=1 num=12", irq_req, irq_num); end
    endtask

    task automatic test_nmi;
        int lat;
        do_reset();
        gie = 0; irq_in = 14'h3FFF; inst_bnd = 1; nmi_evt = 1;
        step(); nmi_evt = 0; lat = 1;
        while (irq_req !== 1'b1 && lat < 10) begin step(); lat++; end
        tests++; if (lat != NMI_LAT) begin fails++; $display("FAIL nmi_latency: got %0d want %0d", lat, NMI_LAT); end
        tests++; if (irq_num !== 4'd14) begin fails++; $display("FAIL nmi_num: got %0d want 14", irq_num); end
        irq_ack = 1; step(); irq_ack = 0;
        tests++; if (nmi_acc !== 1'b1 || irq_acc !== 14'h0) begin fails++;
            $display("FAIL nmi_ack: got nmi_acc=%0b acc=%h want nmi_acc=1 acc=0000", nmi_acc, irq_acc); end
        step();
        tests++; if (nmi_acc !== 1'b0) begin fails++; $display("FAIL nmi_ack_width: got %0b want 0", nmi_acc); end
        repeat (5) step();
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL nmi_cleared: got req=%0b want 0", irq_req); end
    endtask

    task automatic test_withdraw;
        do_reset();
        irq_in = 14'h0020; gie = 1; inst_bnd = 1;
        step();
        tests++; if (irq_req !== 1'b1 || irq_num !== 4'd5) begin fails++;
            $display("FAIL wd_req: got req=%0b num=%0d want req=1 num=5", irq_req, irq_num); end
        irq_in = '0;
        step();
        tests++; if (irq_req !== 1'b0 || irq_acc !== 14'h0) begin fails++;
            $display("FAIL wd_drop: got req=%0b acc=%h want req=0 acc=0000", irq_req, irq_acc); end
        step();
        tests++; if (irq_acc !== 14'h0) begin fails++; $display("FAIL wd_noacc: got acc=%h want 0000", irq_acc); end
        do_reset();
        irq_in = 14'h0020; gie = 1; inst_bnd = 1;
        step();
        irq_in = '0; irq_ack = 1; step(); irq_ack = 0;
        tests++; if (irq_acc !== 14'h0020) begin fails++; $display("FAIL wd_ack_wins: got acc=%h want 0020", irq_acc); end
    endtask

    task automatic test_wdt;
        do_reset();
        wdt_irq = 1; gie = 0; inst_bnd = 1;
        step(); step();
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL wdt_masked: got req=%0b want 0", irq_req); end
        gie = 1;
        step();
        tests++; if (irq_req !== 1'b1 || irq_num !== 4'(WDT_VEC)) begin fails++;
            $display("FAIL wdt_num: got req=%0b num=%0d want req=1 num=%0d", irq_req, irq_num, WDT_VEC); end
        irq_ack = 1; step(); irq_ack = 0;
        tests++; if (irq_acc !== 14'h0400) begin fails++; $display("FAIL wdt_acc: got %h want 0400", irq_acc); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        irq_in = 14'h0080; gie = 1; inst_bnd = 1;
        step();
        irq_ack = 1; step(); irq_ack = 0;
        tests++; if (irq_acc !== 14'h0080) begin fails++; $display("FAIL mid_ack: got acc=%h want 0080", irq_acc); end
        #2 puc = 1;
        #1;
        tests++; if (irq_acc !== 14'h0 || irq_req !== 1'b0 || nmi_acc !== 1'b0) begin fails++;
            $display("FAIL mid_async_clear: got acc=%h req=%0b nmi_acc=%0b want all 0", irq_acc, irq_req, nmi_acc); end
        step(); puc = 0;
        step();
        tests++; if (irq_req !== 1'b1 || irq_num !== 4'd7) begin fails++;
            $display("FAIL mid_idle: got req=%0b num=%0d want req=1 num=7", irq_req, irq_num); end
    endtask

`ifdef IRQ_NMI_SYNC_EN
    task automatic test_nmi_held;
        int pulses = 0;
        do_reset();
        inst_bnd = 1; nmi_evt = 1;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) nmi_evt = 0;
            irq_ack = irq_req;
            step();
            if (nmi_acc === 1'b1) pulses++;
        end
        irq_ack = 0;
        tests++; if (pulses != 1) begin fails++; $display("FAIL nmi_held: got %0d pulses want 1", pulses); end
    endtask
`endif

    task automatic test_random;
        logic [13:0] lines;
        logic        wdt, ge, nmi, any, any2, simul, b2b;
        logic [3:0]  exp, exp2;
        int          pre;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            lines = 14'($urandom) & 14'($urandom);
            if ($urandom_range(0, 3) == 0) lines = '0;
            wdt = ($urandom_range(0, 3) == 0);
            ge  = ($urandom_range(0, 4) != 0);
            nmi = ($urandom_range(0, 4) == 0);
            irq_in = lines; wdt_irq = wdt; gie = ge; inst_bnd = 0; nmi_evt = nmi;
            pre = nmi ? 5 : $urandom_range(0, 2);
            for (int c = 0; c < pre; c++) begin
                step(); nmi_evt = 0;
                tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL rnd_nobnd: it=%0d got req=%0b want 0", it, irq_req); end
            end
            nmi_evt = 0; inst_bnd = 1;
            model_winner(nmi, lines, wdt, ge, exp, any);
            step();
            tests++; if (irq_req !== any || (any && irq_num !== exp)) begin fails++;
                $display("FAIL rnd_arb: it=%0d got req=%0b num=%0d want req=%0b num=%0d", it, irq_req, irq_num, any, exp); end
            if (any) begin
                for (int c = 0; c < $urandom_range(0, 2); c++) begin
                    irq_in = irq_in | 14'($urandom);
                    step();
                    tests++; if (irq_req !== 1'b1 || irq_num !== exp) begin fails++;
                        $display("FAIL rnd_lock: it=%0d got req=%0b num=%0d want req=1 num=%0d", it, irq_req, irq_num, exp); end
                end
                if (exp == 4'd14 && $urandom_range(0, 1) == 1) begin
                    gie = 0;
                    step();
                    tests++; if (irq_req !== 1'b1 || irq_num !== 4'd14) begin fails++;
                        $display("FAIL rnd_nmi_kept: it=%0d got req=%0b num=%0d want req=1 num=14", it, irq_req, irq_num); end
                end
                if (exp != 4'd14 && $urandom_range(0, 3) == 0) begin
                    irq_in = '0; wdt_irq = 0;
                    step();
                    tests++; if (irq_req !== 1'b0 || irq_acc !== 14'h0) begin fails++;
                        $display("FAIL rnd_withdraw: it=%0d got req=%0b acc=%h want req=0 acc=0000", it, irq_req, irq_acc); end
                end else begin
                    simul = (exp != 4'd14) && ($urandom_range(0, 2) == 0);
                    if (simul) begin irq_in = '0; wdt_irq = 0; end
                    irq_ack = 1; step(); irq_ack = 0;
                    tests++;
                    if (irq_req !== 1'b0 || nmi_acc !== (exp == 4'd14) ||
                        irq_acc !== ((exp == 4'd14) ? 14'h0 : (14'd1 << exp))) begin fails++;
                        $display("FAIL rnd_ack: it=%0d got req=%0b acc=%h nmi_acc=%0b for vector %0d", it, irq_req, irq_acc, nmi_acc, exp); end
                    b2b = !simul && ($urandom_range(0, 1) == 1);
                    if (!b2b) begin irq_in = '0; wdt_irq = 0; end
                    model_winner(0, irq_in, wdt_irq, gie, exp2, any2);
                    for (int c = 0; c < HOLDOFF + 1; c++) begin
                        step();
                        tests++; if (irq_req !== 1'b0 || irq_acc !== 14'h0 || nmi_acc !== 1'b0) begin fails++;
                            $display("FAIL rnd_hold: it=%0d got req=%0b acc=%h nmi_acc=%0b want all 0", it, irq_req, irq_acc, nmi_acc); end
                    end
                    step();
                    tests++; if (irq_req !== any2 || (any2 && irq_num !== exp2)) begin fails++;
                        $display("FAIL rnd_b2b: it=%0d got req=%0b num=%0d want req=%0b num=%0d", it, irq_req, irq_num, any2, exp2); end
                    if (any2) begin
                        irq_in = '0; wdt_irq = 0;
                        step();
                    end
                end
            end
            irq_in = '0; wdt_irq = 0; inst_bnd = 0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_priority_lock();
        test_nmi();
        test_withdraw();
        test_wdt();
        test_reset_mid();
`ifdef IRQ_NMI_SYNC_EN
        test_nmi_held();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
